data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Memory-side responder for the memory functional unit's request port. It accepts one load, store or output request per handshake and executes it against an on-chip single-port word RAM or the byte output stream. Load results go back onto the common data bus (CDB) as `{rsv_id, data}`. It sits between the memory functional unit's `o_*` request outputs and the CDB arbiter.

## Interface
- `ADDR_W`, 12: RAM word-address width; depth is 2**ADDR_W words of DATA_W bits.
- `DATA_W`, `RSV_ID_W`, `INSTR_W`, `CDB_W` (= RSV_ID_W+DATA_W): taken from fcpu_pkg.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `i_valid`  in  1  request valid.
- `i_opcode`  in  INSTR_W  I_LOAD, I_LOADB, I_STORE, I_STOREB, I_STORER, I_OUTPUT.
- `i_rsv_id`  in  RSV_ID_W  ROB id of the request.
- `i_address`  in  DATA_W  word address; only bits [ADDR_W-1:0] are used.
- `i_data`  in  DATA_W  store/output data.
- `i_ready`  out  1  request accepted when `i_valid & i_ready`.
- `o_cdb`  out  CDB_W  `{rsv_id, load_data}`.
- `o_cdb_valid`  out  1  load result valid.
- `o_cdb_ready`  in  1  CDB arbiter grant.
- `out_valid`  out  1  output byte valid.
- `out_data`  out  8  output byte.
- `out_ready`  in  1  output sink ready.
- `illegal_op`  out  1  sticky flag: an unknown opcode was accepted.

## Operation
- State machine states: IDLE, RESP, OUT. `i_ready = (state == IDLE)`; nothing is combinationally dependent on `i_valid`.
- IDLE:
  - On accept of STORE/STOREB/STORER: write `i_data` to `ram[i_address[ADDR_W-1:0]]` at that edge and stay in IDLE. Stores sustain 1 per cycle.
  - On accept of LOAD/LOADB: issue the RAM read, latch `i_rsv_id`, go to RESP.
  - On accept of OUTPUT: latch `i_data[7:0]`, go to OUT.
  - On accept of any other opcode: drop it, set `illegal_op`, stay in IDLE.
- LOAD and LOADB are identical here; STOREB and STORER are identical to STORE. Address arithmetic is done upstream.
- RESP:
  - `o_cdb_valid = 1`; `o_cdb = {latched rsv_id, RAM read data}`.
  - The RAM read port is not re-enabled, so its output stays stable while stalled.
  - On `o_cdb_ready`, go to IDLE.
- OUT:
  - `out_valid = 1`; `out_data` = latched byte.
  - On `out_ready`, go to IDLE.
- No broadcast is made for stores or outputs; they are already committed upstream.
- Address bits above ADDR_W are ignored, so addresses wrap modulo the RAM depth.
- RAM contents are not cleared by reset and are undefined after power-up.

## Timing
- Reset values: state IDLE, `i_ready` 1 (from the first cycle after reset), `o_cdb_valid` 0, `o_cdb` 0, `out_valid` 0, `out_data` 0, `illegal_op` 0.
- Load accepted at edge T: `o_cdb_valid` is high from cycle T+1 (1-cycle RAM read latency). It holds, with `o_cdb` stable, until the cycle in which `o_cdb_ready = 1`. In that cycle the handshake completes and `i_ready = 0`; `i_ready = 1` in the next cycle. Load throughput is 1 per 2 cycles with no backpressure.
- Store at edge T followed by a load of the same address accepted at edge T+1 returns the new data. The write completes before the read cycle.
- Output accepted at edge T: `out_valid` is high from T+1 until the `out_ready` handshake.
- Reset asserted in RESP or OUT: the pending response or byte is discarded. Valids go low in the cycle after the reset edge, and state returns to IDLE.
- `o_cdb_ready` or `out_ready` asserted while no valid is pending: ignored.

## Test plan
- Reset, then store 0xDEADBEEF to addr 5 at edge T, then load addr 5 with rsv_id 3 at T+1 -> `o_cdb = {3, 0xDEADBEEF}` with `o_cdb_valid` high at T+2, `o_cdb_ready = 1` -> `i_ready` high at T+3.
- Hold `o_cdb_ready = 0` for 5 cycles after a load of addr 7 (holding 0x11) -> `o_cdb_valid` and `o_cdb` stable for all 5 cycles and `i_ready = 0`. Release ready -> exactly one handshake.
- Four back-to-back stores to addrs 0..3 (values 1..4) on consecutive edges -> `i_ready` high throughout. Subsequent loads return 1..4 in order.
- Store 0xAA to address `2**ADDR_W + 9`, then load addr 9 -> returns 0xAA.
- OUTPUT with `i_data = 0x1234_5641` and `out_ready` low 3 cycles -> `out_data = 0x41` held, single transfer, no CDB activity.
- Assert `rst` while in RESP -> `o_cdb_valid = 0` after the edge, state IDLE. An unknown opcode afterwards sets `illegal_op` until the next reset.

Source files
------------

// File: rtl/data_memory_responder.sv
// Memory-side responder: executes load/store/output requests against a
// single-port word RAM or a byte output stream and returns load results to the CDB.
package fcpu_pkg;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned RSV_ID_W = 4;
  localparam int unsigned INSTR_W  = 6;
  localparam int unsigned CDB_W    = RSV_ID_W + DATA_W;

  localparam logic [INSTR_W-1:0] I_LOAD   = 6'h01;
  localparam logic [INSTR_W-1:0] I_LOADB  = 6'h02;
  localparam logic [INSTR_W-1:0] I_STORE  = 6'h03;
  localparam logic [INSTR_W-1:0] I_STOREB = 6'h04;
  localparam logic [INSTR_W-1:0] I_STORER = 6'h05;
  localparam logic [INSTR_W-1:0] I_OUTPUT = 6'h06;
endpackage

module data_memory_responder
  import fcpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [INSTR_W-1:0]  i_opcode,
  input  logic [RSV_ID_W-1:0] i_rsv_id,
  input  logic [DATA_W-1:0]   i_address,
  input  logic [DATA_W-1:0]   i_data,
  output logic                i_ready,
  output logic [CDB_W-1:0]    o_cdb,
  output logic                o_cdb_valid,
  input  logic                o_cdb_ready,
  output logic                out_valid,
  output logic [7:0]          out_data,
  input  logic                out_ready,
  output logic                illegal_op
);

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    OUT
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]   mem [2**ADDR_W];
  logic [DATA_W-1:0]   rd_q;
  logic [RSV_ID_W-1:0] rsv_q;
  logic [7:0]          byte_q;
  logic                illegal_q, illegal_d;

  logic              accept;
  logic              is_load, is_store, is_out;
  logic [ADDR_W-1:0] word_addr;
  logic              unused_addr_bits;

  // Upper address bits are dropped so addresses wrap modulo the RAM depth.
  assign word_addr        = i_address[ADDR_W-1:0];
  assign unused_addr_bits = ^i_address[DATA_W-1:ADDR_W];
  assign accept           = i_valid && (state_q == IDLE);

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_out   = 1'b0;
    unique case (i_opcode)
      I_LOAD, I_LOADB:             is_load  = 1'b1;
      I_STORE, I_STOREB, I_STORER: is_store = 1'b1;
      I_OUTPUT:                    is_out   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_load)       state_d = RESP;
          else if (is_out)   state_d = OUT;
          else if (!is_store) illegal_d = 1'b1;
        end
      end
      RESP:    if (o_cdb_ready) state_d = IDLE;
      OUT:     if (out_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_ready     = (state_q == IDLE);
    o_cdb_valid = (state_q == RESP);
    o_cdb       = (state_q == RESP) ? {rsv_q, rd_q} : '0;
    out_valid   = (state_q == OUT);
    out_data    = (state_q == OUT) ? byte_q : '0;
    illegal_op  = illegal_q;
  end

  // RAM read port only fires on load accept, so rd_q holds steady through a stall.
  always_ff @(posedge clk) begin
    if (accept && is_store) mem[word_addr] <= i_data;
    if (accept && is_load) begin
      rd_q  <= mem[word_addr];
      rsv_q <= i_rsv_id;
    end
    if (accept && is_out) byte_q <= i_data[7:0];
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench for data_memory_responder.
module tb_data_memory_responder;
  import fcpu_pkg::*;

  localparam int unsigned ADDR_W = 12;

  logic                clk = 1'b0;
  logic                rst;
  logic                i_valid;
  logic [INSTR_W-1:0]  i_opcode;
  logic [RSV_ID_W-1:0] i_rsv_id;
  logic [DATA_W-1:0]   i_address;
  logic [DATA_W-1:0]   i_data;
  logic                i_ready;
  logic [CDB_W-1:0]    o_cdb;
  logic                o_cdb_valid;
  logic                o_cdb_ready;
  logic                out_valid;
  logic [7:0]          out_data;
  logic                out_ready;
  logic                illegal_op;

  int tests_run = 0;
  int tests_failed = 0;
  int cdb_hs = 0;
  int out_hs = 0;

  data_memory_responder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_opcode   (i_opcode),
    .i_rsv_id   (i_rsv_id),
    .i_address  (i_address),
    .i_data     (i_data),
    .i_ready    (i_ready),
    .o_cdb      (o_cdb),
    .o_cdb_valid(o_cdb_valid),
    .o_cdb_ready(o_cdb_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && o_cdb_valid && o_cdb_ready) cdb_hs <= cdb_hs + 1;
    if (!rst && out_valid && out_ready)     out_hs <= out_hs + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] data);
    i_valid = 1'b1; i_opcode = I_STORE; i_address = addr; i_data = data;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic do_load(input logic [DATA_W-1:0] addr, input logic [RSV_ID_W-1:0] id);
    i_valid = 1'b1; i_opcode = I_LOAD; i_address = addr; i_rsv_id = id;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic load_expect(input string tag, input logic [DATA_W-1:0] addr,
                             input logic [RSV_ID_W-1:0] id, input logic [DATA_W-1:0] exp);
    do_load(addr, id);
    check({tag, "_valid"}, 64'(o_cdb_valid), 64'd1);
    check({tag, "_cdb"}, 64'(o_cdb), 64'({id, exp}));
    o_cdb_ready = 1'b1;
    tick();
    o_cdb_ready = 1'b0;
    check({tag, "_done"}, 64'(o_cdb_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_opcode = '0; i_rsv_id = '0;
    i_address = '0; i_data = '0; o_cdb_ready = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_i_ready", 64'(i_ready), 64'd1);
    check("rst_cdb_valid", 64'(o_cdb_valid), 64'd0);
    check("rst_cdb", 64'(o_cdb), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_illegal", 64'(illegal_op), 64'd0);

    // Store then immediate load of the same address.
    do_store(32'd5, 32'hDEADBEEF);
    check("st_i_ready", 64'(i_ready), 64'd1);
    do_load(32'd5, 4'd3);
    check("ld_valid", 64'(o_cdb_valid), 64'd1);
    check("ld_cdb", 64'(o_cdb), 64'h3_DEADBEEF);
    check("ld_i_ready", 64'(i_ready), 64'd0);
    o_cdb_ready = 1'b1;
    check("ld_hs_i_ready", 64'(i_ready), 64'd0);
    tick();
    o_cdb_ready = 1'b0;
    check("ld_after_i_ready", 64'(i_ready), 64'd1);
    check("ld_after_valid", 64'(o_cdb_valid), 64'd0);

    // Stalled response stays stable.
    do_store(32'd7, 32'h11);
    do_load(32'd7, 4'd5);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(o_cdb_valid), 64'd1);
      check("stall_cdb", 64'(o_cdb), 64'h5_00000011);
      check("stall_i_ready", 64'(i_ready), 64'd0);
      tick();
    end
    o_cdb_ready = 1'b1;
    tick();
    o_cdb_ready = 1'b0;
    check("stall_release_valid", 64'(o_cdb_valid), 64'd0);
    check("stall_hs_count", 64'(cdb_hs), 64'd2);

    // Back-to-back stores.
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_opcode = I_STORE; i_address = 32'(i); i_data = 32'(i + 1);
      check("b2b_i_ready", 64'(i_ready), 64'd1);
      tick();
    end
    i_valid = 1'b0;
    check("b2b_end_i_ready", 64'(i_ready), 64'd1);
    for (int i = 0; i < 4; i++) load_expect("b2b_ld", 32'(i), 4'(i + 8), 32'(i + 1));

    // Address wrap.
    do_store(32'(2**ADDR_W + 9), 32'hAA);
    load_expect("wrap", 32'd9, 4'd1, 32'hAA);
    check("cdb_hs_total", 64'(cdb_hs), 64'd7);

    // Output byte with backpressure.
    i_valid = 1'b1; i_opcode = I_OUTPUT; i_data = 32'h1234_5641;
    tick();
    i_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("out_valid", 64'(out_valid), 64'd1);
      check("out_data", 64'(out_data), 64'h41);
      check("out_no_cdb", 64'(o_cdb_valid), 64'd0);
      check("out_i_ready", 64'(i_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_done_valid", 64'(out_valid), 64'd0);
    check("out_hs_count", 64'(out_hs), 64'd1);
    check("out_cdb_hs_unchanged", 64'(cdb_hs), 64'd7);

    // Grants while idle are ignored.
    o_cdb_ready = 1'b1; out_ready = 1'b1;
    tick();
    o_cdb_ready = 1'b0; out_ready = 1'b0;
    check("idle_grant_cdb", 64'(o_cdb_valid), 64'd0);
    check("idle_grant_out", 64'(out_valid), 64'd0);

    // Reset in RESP discards the response.
    do_load(32'd5, 4'd2);
    check("pre_rst_valid", 64'(o_cdb_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_resp_valid", 64'(o_cdb_valid), 64'd0);
    check("rst_resp_cdb", 64'(o_cdb), 64'd0);
    check("rst_resp_i_ready", 64'(i_ready), 64'd1);

    // Unknown opcode sets a sticky flag.
    i_valid = 1'b1; i_opcode = 6'h3F;
    tick();
    i_valid = 1'b0;
    check("illegal_set", 64'(illegal_op), 64'd1);
    check("illegal_i_ready", 64'(i_ready), 64'd1);
    do_store(32'd1, 32'h55);
    tick();
    check("illegal_sticky", 64'(illegal_op), 64'd1);
    load_expect("post_illegal_ld", 32'd1, 4'd4, 32'h55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("illegal_cleared", 64'(illegal_op), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
